edge_counter: RTL and testbench

Parametrised, mode-selectable event counter. It is the next generation of the single-bit clocked counter/toggler in the Verilog_counter project. It counts either enabled clock cycles or detected edges of a single input, within a configurable modulus. Direction, wrap or saturate behaviour, and parallel load are all selectable. It drives a registered terminal-count pulse and a divided-clock toggle output for downstream blocks.

---
 rtl/counter_pkg.sv | 13 +
 rtl/edge_detect.sv | 30 +++
 rtl/edge_counter.sv | 119 +++++++++++
 tb/tb_edge_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the counter family
package counter_pkg;

    // Event source selection
    localparam int EM_LEVEL = 0;
    localparam int EM_RISE  = 1;
    localparam int EM_BOTH  = 2;

    // Count direction as seen on the dir input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - single-input rise/fall detector
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise,
    output logic fall
);

    logic in_q;
    logic in_d;

    assign in_d = in;

    // Previous-cycle sample of in; runs every cycle regardless of enable or load
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    // A high input right after reset reads as a rising edge since in_q starts low
    always_comb begin
        rise = in & ~in_q;
        fall = ~in & in_q;
    end

endmodule

// File: rtl/edge_counter.sv
// rtl/edge_counter.sv - mode-selectable modulo event counter with tc/out/ovf
module edge_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODULO    = 10,
    parameter int EDGE_MODE = EM_RISE,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             out,
    output logic             ovf
);

    // Top of the count range; for MODULO = 2^WIDTH this is all ones
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    // One bit wider so MODULO = 2^WIDTH is representable in the load clamp
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic             rise;
    logic             fall;
    logic             event_w;
    logic [WIDTH-1:0] load_clamped;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             out_q, out_d;
    logic             ovf_q, ovf_d;

    edge_detect u_edge_detect (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .rise  (rise),
        .fall  (fall)
    );

    // Event source mux; mode 2 yields at most one event per cycle
    always_comb begin
        event_w = 1'b0;
        case (EDGE_MODE)
            EM_LEVEL: event_w = en;
            EM_RISE:  event_w = en & rise;
            EM_BOTH:  event_w = en & (rise | fall);
            default:  event_w = 1'b0;
        endcase
    end

    // Out-of-range load values are pinned to the top of the range
    always_comb begin
        load_clamped = load_val;
        if ({1'b0, load_val} >= MOD_EXT) begin
            load_clamped = MAX_VAL;
        end
    end

    // Next-state: load beats event; tc only on wrap; ovf set beats clear
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        out_d   = out_q;
        ovf_d   = ovf_q & ~clr_ovf;
        if (load) begin
            count_d = load_clamped;
        end else if (event_w) begin
            if (dir == DIR_UP) begin
                if (count_q != MAX_VAL) begin
                    count_d = count_q + 1'b1;
                end else if (SATURATE != 0) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = '0;
                    tc_d    = 1'b1;
                    out_d   = ~out_q;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else if (SATURATE != 0) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = MAX_VAL;
                    tc_d    = 1'b1;
                    out_d   = ~out_q;
                end
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            out_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign out   = out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_edge_counter.sv
// tb/tb_edge_counter.sv - scoreboard bench for edge_counter across several configurations
module tb_edge_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       in_s = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       clr_ovf = 1'b0;

    logic [7:0] c0, c1, c2, c3;
    logic [3:0] c4;
    logic       tc0, tc1, tc2, tc3, tc4;
    logic       o0, o1, o2, o3, o4;
    logic       v0, v1, v2, v3, v4;

    typedef struct {
        int         id;
        int         cyc;
        logic [7:0] cnt;
        logic       tc;
        logic       out;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    edge_counter #(.WIDTH(8), .MODULO(10), .EDGE_MODE(EM_LEVEL), .SATURATE(0)) d0 (
        .clk(clk), .reset(reset), .en(en), .in(in_s), .dir(dir), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(c0), .tc(tc0), .out(o0), .ovf(v0));
    edge_counter #(.WIDTH(8), .MODULO(10), .EDGE_MODE(EM_RISE), .SATURATE(0)) d1 (
        .clk(clk), .reset(reset), .en(en), .in(in_s), .dir(dir), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(c1), .tc(tc1), .out(o1), .ovf(v1));
    edge_counter #(.WIDTH(8), .MODULO(10), .EDGE_MODE(EM_BOTH), .SATURATE(0)) d2 (
        .clk(clk), .reset(reset), .en(en), .in(in_s), .dir(dir), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(c2), .tc(tc2), .out(o2), .ovf(v2));
    edge_counter #(.WIDTH(8), .MODULO(10), .EDGE_MODE(EM_LEVEL), .SATURATE(1)) d3 (
        .clk(clk), .reset(reset), .en(en), .in(in_s), .dir(dir), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(c3), .tc(tc3), .out(o3), .ovf(v3));
    edge_counter #(.WIDTH(4), .MODULO(16), .EDGE_MODE(EM_LEVEL), .SATURATE(0)) d4 (
        .clk(clk), .reset(reset), .en(en), .in(in_s), .dir(dir), .load(load),
        .load_val(load_val[3:0]), .clr_ovf(clr_ovf), .count(c4), .tc(tc4), .out(o4), .ovf(v4));

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
        end
    end

    task automatic drive(input logic r, input logic e, input logic i, input logic d,
                         input logic l, input logic [7:0] lv, input logic c);
        reset    = r;
        en       = e;
        in_s     = i;
        dir      = d;
        load     = l;
        load_val = lv;
        clr_ovf  = c;
    endtask

    task automatic expect_state(input int id, input int cnt, input logic t,
                                input logic o, input logic v);
        exp_t e;
        e.id  = id;
        e.cyc = cyc_cnt + 1;
        e.cnt = 8'(cnt);
        e.tc  = t;
        e.out = o;
        e.ovf = v;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops every expectation whose cycle has arrived and compares
    initial begin
        exp_t       e;
        logic [7:0] a_cnt;
        logic       a_tc, a_out, a_ovf;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
                e = q.pop_front();
                case (e.id)
                    0: begin a_cnt = c0; a_tc = tc0; a_out = o0; a_ovf = v0; end
                    1: begin a_cnt = c1; a_tc = tc1; a_out = o1; a_ovf = v1; end
                    2: begin a_cnt = c2; a_tc = tc2; a_out = o2; a_ovf = v2; end
                    3: begin a_cnt = c3; a_tc = tc3; a_out = o3; a_ovf = v3; end
                    default: begin a_cnt = {4'd0, c4}; a_tc = tc4; a_out = o4; a_ovf = v4; end
                endcase
                n_checks++;
                if ({a_cnt, a_tc, a_out, a_ovf} !== {e.cnt, e.tc, e.out, e.ovf}) begin
                    n_fail++;
                    $display("FAIL dut%0d cyc %0d: got count=%0d tc=%b out=%b ovf=%b, required count=%0d tc=%b out=%b ovf=%b",
                             e.id, cyc_cnt, a_cnt, a_tc, a_out, a_ovf, e.cnt, e.tc, e.out, e.ovf);
                end
            end
        end
    end

    initial begin
        int waited;
        tick();

        // Reset values on every configuration
        drive(1, 0, 0, 1, 0, 8'd0, 0);
        for (int id = 0; id < 5; id++) expect_state(id, 0, 0, 0, 0);
        tick();

        // Level mode: 0..9 wrap to 0 with tc/out, on to 5, then reset
        for (int k = 1; k <= 15; k++) begin
            drive(0, 1, 0, 1, 0, 8'd0, 0);
            expect_state(0, k % 10, (k == 10), (k >= 10), 0);
            tick();
        end
        drive(1, 1, 0, 1, 0, 8'd0, 0);
        expect_state(0, 0, 0, 0, 0);
        tick();

        // Rising-edge mode: 8 edges counted, then 3 edges with en low ignored
        drive(1, 0, 0, 1, 0, 8'd0, 0);
        expect_state(1, 0, 0, 0, 0);
        tick();
        for (int j = 0; j < 16; j++) begin
            drive(0, 1, (j % 2 == 0), 1, 0, 8'd0, 0);
            expect_state(1, j / 2 + 1, 0, 0, 0);
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            drive(0, 0, (j % 2 == 0), 1, 0, 8'd0, 0);
            expect_state(1, 8, 0, 0, 0);
            tick();
        end

        // Both-edge mode: one count per toggle
        drive(1, 0, 0, 1, 0, 8'd0, 0);
        expect_state(2, 0, 0, 0, 0);
        tick();
        for (int j = 0; j < 4; j++) begin
            drive(0, 1, (j % 2 == 0), 1, 0, 8'd0, 0);
            expect_state(2, j + 1, 0, 0, 0);
            tick();
        end

        // Down wrap from 0
        drive(1, 0, 0, 0, 0, 8'd0, 0);
        expect_state(0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 8'd0, 0);
        expect_state(0, 9, 1, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 8'd0, 0);
        expect_state(0, 8, 0, 1, 0);
        tick();

        // Saturating: blocked down, sticky ovf, set beats clear, then clear
        drive(1, 0, 0, 0, 0, 8'd0, 0);
        expect_state(3, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 8'd0, 0);
        expect_state(3, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 8'd0, 0);
        expect_state(3, 0, 0, 0, 1);
        tick();
        drive(0, 1, 0, 0, 0, 8'd0, 1);
        expect_state(3, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 8'd0, 1);
        expect_state(3, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 8'd9, 0);
        expect_state(3, 9, 0, 0, 0);
        tick();
        drive(0, 1, 0, 1, 0, 8'd0, 0);
        expect_state(3, 9, 0, 0, 1);
        tick();

        // Load beats event, clamps, never pulses tc
        drive(1, 0, 0, 1, 0, 8'd0, 0);
        expect_state(0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 1, 1, 8'd7, 0);
        expect_state(0, 7, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 8'd15, 0);
        expect_state(0, 9, 0, 0, 0);
        tick();
        drive(0, 1, 0, 1, 1, 8'd9, 0);
        expect_state(0, 9, 0, 0, 0);
        tick();
        drive(0, 1, 0, 1, 0, 8'd0, 0);
        expect_state(0, 0, 1, 1, 0);
        tick();

        // Full-range 4-bit counter: up from 15 wraps to 0, down from 0 to 15
        drive(1, 0, 0, 1, 0, 8'd0, 0);
        expect_state(4, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 8'd15, 0);
        expect_state(4, 15, 0, 0, 0);
        tick();
        drive(0, 1, 0, 1, 0, 8'd0, 0);
        expect_state(4, 0, 1, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 8'd0, 0);
        expect_state(4, 15, 1, 0, 0);
        tick();

        drive(0, 0, 0, 1, 0, 8'd0, 0);
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            tick();
            waited++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations still queued, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
